io_pad_arbiter: RTL and testbench

- Shares one muxable iCE40 IO pad between REQCOUNT requesters.
- Drives the pad's func_select using round-robin arbitration with a req/grant handshake.
- Parks the pad on a safe idle (receive) function between owners and inserts guard cycles at each owner change, so two output drivers never overlap across a function switch.
- Sits directly in front of the pad's func_select input; one instance per shared pin.

---
 rtl/io_pad_arbiter_pkg.sv | 13 +
 rtl/io_pad_arbiter_rr_pick.sv | 31 +++
 rtl/io_pad_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_io_pad_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pad_arbiter_pkg.sv
// State encodings and sizing helper shared by io_pad_arbiter and its sub-blocks.
package io_pad_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  // Index width that stays legal (>= 1 bit) for single-entry arbiters.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_pad_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select. Scans from ptr upward with
// wraparound and reports the first requester found; reusable by other arbiters.
module rr_pick
  import io_pad_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] winner
);

  always_comb begin
    valid  = |req;
    winner = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int off = N - 1; off >= 0; off--) begin
      int s;
      s = int'(ptr) + off;
      if (s >= N) begin
        s = s - N;
      end
      if (req[s]) begin
        winner = PW'(s);
      end
    end
  end

endmodule

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: round-robin owner of one shared iCE40 pad's func_select, with guard
// cycles on IDLE_SELECT between owners. Optional hold timeout: IO_PAD_ARBITER_TIMEOUT_EN.
module io_pad_arbiter
  import io_pad_arbiter_pkg::*;
#(
  parameter int                            REQCOUNT     = 2,
  parameter int                            MUXWIDTH     = 2,
  parameter logic [REQCOUNT*MUXWIDTH-1:0]  SELECT_MAP   = {2'd3, 2'd2},
  parameter logic [MUXWIDTH-1:0]           IDLE_SELECT  = '0,
  parameter int                            GUARD_CYCLES = 2,
  parameter int                            HOLD_LIMIT   = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQCOUNT-1:0] req,
  output logic [REQCOUNT-1:0] grant,
  output logic [MUXWIDTH-1:0] func_select,
  output logic                busy,
  output logic                preempted
);

  localparam int PW         = idx_width(REQCOUNT);
  localparam int GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int GUARD_LOAD = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

  if (REQCOUNT < 1) begin : g_bad_reqcount
    $error("io_pad_arbiter: REQCOUNT must be >= 1");
  end
  if (MUXWIDTH < 1) begin : g_bad_muxwidth
    $error("io_pad_arbiter: MUXWIDTH must be >= 1");
  end
  if (GUARD_CYCLES < 0) begin : g_bad_guard
    $error("io_pad_arbiter: GUARD_CYCLES must be >= 0");
  end
  if (HOLD_LIMIT < 1) begin : g_bad_hold
    $error("io_pad_arbiter: HOLD_LIMIT must be >= 1");
  end

  logic [1:0]          state_reg, state_next;
  logic [PW-1:0]       ptr_reg, ptr_next;
  logic [PW-1:0]       owner_reg, owner_next;
  logic [GW-1:0]       guard_cnt_reg, guard_cnt_next;
  logic [REQCOUNT-1:0] grant_reg, grant_next;
  logic [MUXWIDTH-1:0] func_select_reg, func_select_next;

  logic [REQCOUNT-1:0] eligible;
  logic                pick_valid;
  logic [PW-1:0]       pick_idx;
  logic [REQCOUNT-1:0] pick_onehot;
  logic [MUXWIDTH-1:0] sel_table [REQCOUNT];
  logic                owner_req;
  logic                force_release;
  logic                release_now;

  genvar gi;
  generate
    for (gi = 0; gi < REQCOUNT; gi++) begin : g_req
      assign sel_table[gi]   = SELECT_MAP[gi*MUXWIDTH +: MUXWIDTH];
      assign pick_onehot[gi] = (pick_idx == PW'(gi));
    end
  endgenerate

  assign owner_req   = req[owner_reg];
  assign release_now = (state_reg == ST_OWNED) && (!owner_req || force_release);

  rr_pick #(
    .N  (REQCOUNT),
    .PW (PW)
  ) u_rr_pick (
    .req    (eligible),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef IO_PAD_ARBITER_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_LIMIT + 1);

  logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;
  logic [REQCOUNT-1:0] blocked_reg, blocked_next;
  logic                preempted_reg;

  // A preempted requester stays masked until it has been seen with req low.
  assign force_release = (state_reg == ST_OWNED) && owner_req &&
                         (hold_cnt_reg == HW'(HOLD_LIMIT - 1));
  assign eligible      = req & ~blocked_reg;
  assign hold_cnt_next = ((state_reg == ST_OWNED) && !release_now) ?
                         hold_cnt_reg + 1'b1 : '0;

  generate
    for (gi = 0; gi < REQCOUNT; gi++) begin : g_block
      assign blocked_next[gi] = (blocked_reg[gi] & req[gi]) |
                                (force_release && (owner_reg == PW'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg  <= '0;
      blocked_reg   <= '0;
      preempted_reg <= 1'b0;
    end else begin
      hold_cnt_reg  <= hold_cnt_next;
      blocked_reg   <= blocked_next;
      preempted_reg <= force_release;
    end
  end

  assign preempted = preempted_reg;
`else
  assign force_release = 1'b0;
  assign eligible      = req;
  assign preempted     = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    owner_next       = owner_reg;
    guard_cnt_next   = guard_cnt_reg;
    grant_next       = grant_reg;
    func_select_next = func_select_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next       = ST_OWNED;
          owner_next       = pick_idx;
          ptr_next         = (pick_idx == PW'(REQCOUNT - 1)) ? '0 : pick_idx + 1'b1;
          grant_next       = pick_onehot;
          func_select_next = sel_table[pick_idx];
        end
      end
      ST_OWNED: begin
        // Other requesters are ignored until the owner lets go.
        if (release_now) begin
          grant_next       = '0;
          func_select_next = IDLE_SELECT;
          if (GUARD_CYCLES > 0) begin
            state_next     = ST_GUARD;
            guard_cnt_next = GW'(GUARD_LOAD);
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GUARD: begin
        if (guard_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          guard_cnt_next = guard_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next       = ST_IDLE;
        grant_next       = '0;
        func_select_next = IDLE_SELECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= '0;
      owner_reg       <= '0;
      guard_cnt_reg   <= '0;
      grant_reg       <= '0;
      func_select_reg <= IDLE_SELECT;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      owner_reg       <= owner_next;
      guard_cnt_reg   <= guard_cnt_next;
      grant_reg       <= grant_next;
      func_select_reg <= func_select_next;
    end
  end

  assign grant       = grant_reg;
  assign func_select = func_select_reg;
  assign busy        = (state_reg == ST_OWNED) || (state_reg == ST_GUARD);

endmodule

// File: tb/tb_io_pad_arbiter.sv
// Self-checking bench for io_pad_arbiter: hand-derived vectors, corner sequences and
// a randomized run against an ownership/cooldown reference model.
module tb_io_pad_arbiter;

`ifdef IO_PAD_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int HOLD1 = 4;
  localparam int HOLD2 = 6;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [1:0] req;
  logic [2:0] req2;
  logic [1:0] grant, func_select;
  logic       busy, preempted;
  logic [2:0] grant2;
  logic [1:0] func2;
  logic       busy2, pre2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_pad_arbiter #(
    .REQCOUNT(2), .MUXWIDTH(2), .SELECT_MAP(4'b11_10), .IDLE_SELECT(2'd0),
    .GUARD_CYCLES(2), .HOLD_LIMIT(HOLD1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .func_select(func_select), .busy(busy), .preempted(preempted)
  );

  io_pad_arbiter #(
    .REQCOUNT(3), .MUXWIDTH(2), .SELECT_MAP(6'b01_11_10), .IDLE_SELECT(2'd0),
    .GUARD_CYCLES(0), .HOLD_LIMIT(HOLD2)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .grant(grant2),
    .func_select(func2), .busy(busy2), .preempted(pre2)
  );

  // Reference model: who owns the pad, how long until the next arbitration,
  // who won last, how long the owner has held, and who is locked out.
  typedef struct {
    int       owner;
    int       cool;
    int       last;
    int       held;
    bit [2:0] blocked;
    bit       pre;
  } mdl_t;

  typedef struct {
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] func;
    logic       busy;
  } vec_t;

  function automatic mdl_t mreset(input int n);
    mdl_t m;
    m.owner = -1; m.cool = 0; m.last = n - 1; m.held = 0; m.blocked = '0; m.pre = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic [2:0] r, input int n,
                                 input int g, input int hold);
    mdl_t o;
    o = m;
    o.pre = 0;
    if (m.owner >= 0) begin
      o.held = m.held + 1;
      if (!r[m.owner]) begin
        o.owner = -1; o.cool = g;
      end else if (TO_EN && o.held == hold) begin
        o.owner = -1; o.cool = g; o.pre = 1;
      end
    end else if (m.cool > 0) begin
      o.cool = m.cool - 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (m.last + 1 + k) % n;
        if (r[i] && !m.blocked[i]) begin
          o.owner = i; o.last = i; o.held = 0;
          break;
        end
      end
    end
    for (int i = 0; i < n; i++) o.blocked[i] = m.blocked[i] & r[i];
    if (o.pre) o.blocked[m.owner] = 1'b1;
    return o;
  endfunction

  function automatic logic [2:0] mgrant(input mdl_t m);
    return (m.owner >= 0) ? (3'b001 << m.owner) : 3'b000;
  endfunction

  function automatic logic [1:0] mfunc(input mdl_t m, input logic [5:0] map);
    return (m.owner >= 0) ? map[m.owner*2 +: 2] : 2'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [12];
  mdl_t m1, m2;
  logic [2:0] eg;

  initial begin
    vt[0]  = '{2'b00, 2'b00, 2'd0, 1'b0};
    vt[1]  = '{2'b10, 2'b10, 2'd3, 1'b1};
    vt[2]  = '{2'b11, 2'b10, 2'd3, 1'b1};
    vt[3]  = '{2'b01, 2'b00, 2'd0, 1'b1};
    vt[4]  = '{2'b01, 2'b00, 2'd0, 1'b1};
    vt[5]  = '{2'b01, 2'b00, 2'd0, 1'b0};
    vt[6]  = '{2'b01, 2'b01, 2'd2, 1'b1};
    vt[7]  = '{2'b11, 2'b01, 2'd2, 1'b1};
    vt[8]  = '{2'b10, 2'b00, 2'd0, 1'b1};
    vt[9]  = '{2'b10, 2'b00, 2'd0, 1'b1};
    vt[10] = '{2'b10, 2'b00, 2'd0, 1'b0};
    vt[11] = '{2'b11, 2'b10, 2'd3, 1'b1};

    rst_n = 1'b0; rst2_n = 1'b0; req = 2'b11; req2 = 3'b000;

    // Reset held with both requesting, then first grant one cycle after release.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_grant", grant, 2'b00);
      chk("rst_func", func_select, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pre", preempted, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_grant", grant, 2'b01);
    chk("post_rst_func", func_select, 2'd2);
    $display("reset release: grant=%b func=%0d", grant, func_select);

    // Fairness: both held, each owner pulses req low for one cycle.
    for (int k = 0; k < 8; k++) begin
      int w;
      w = 0;
      while (grant == 2'b00 && w < 10) begin
        tick();
        w++;
      end
      chk("fair_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      $display("fair ownership %0d: grant=%b after %0d waits", k, grant, w);
      req = 2'b11 & ~grant;
      tick();
      req = 2'b11;
    end

    // Reset between edges while owned must clear outputs immediately.
    begin
      int w;
      w = 0;
      while (grant == 2'b00 && w < 10) begin
        tick();
        w++;
      end
      chk("mid_own_granted", (grant != 2'b00), 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant, 2'b00);
    chk("async_rst_func", func_select, 2'd0);
    chk("async_rst_busy", busy, 1'b0);
    $display("async reset: grant=%b func=%0d", grant, func_select);
    req = 2'b00;
    tick();
    rst_n = 1'b1;

    // Hand-derived vector table from a fresh reset (pointer at 0).
    for (int i = 0; i < 12; i++) begin
      req = vt[i].req;
      tick();
      $display("vec %0d: req=%b grant=%b func=%0d busy=%b", i, req, grant, func_select, busy);
      chk("vec_grant", grant, vt[i].grant);
      chk("vec_func", func_select, vt[i].func);
      chk("vec_busy", busy, vt[i].busy);
      chk("vec_pre", preempted, 1'b0);
    end

    // Zero guard, three requesters: r1 releases while r2 waits.
    rst2_n = 1'b1;
    req2 = 3'b010;
    tick();
    chk("g0_first", grant2, 3'b010);
    req2 = 3'b110;
    tick();
    chk("g0_hold", grant2, 3'b010);
    chk("g0_hold_func", func2, 2'd3);
    req2 = 3'b100;
    tick();
    chk("g0_gap", grant2, 3'b000);
    chk("g0_gap_busy", busy2, 1'b0);
    chk("g0_gap_func", func2, 2'd0);
    tick();
    chk("g0_next", grant2, 3'b100);
    chk("g0_next_func", func2, 2'd1);
    $display("guard0 handover: grant=%b func=%0d", grant2, func2);

`ifdef IO_PAD_ARBITER_TIMEOUT_EN
    // Hold timeout: four owned cycles, a one-cycle preempt pulse, no regrant while held.
    rst_n = 1'b0;
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_owned", grant, 2'b01);
      chk("to_no_pre", preempted, 1'b0);
    end
    tick();
    chk("to_release", grant, 2'b00);
    chk("to_pulse", preempted, 1'b1);
    chk("to_busy", busy, 1'b1);
    tick();
    chk("to_pulse_end", preempted, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("to_locked", grant, 2'b00);
    end
    req = 2'b00;
    tick();
    req = 2'b01;
    begin
      int w;
      w = 0;
      while (grant == 2'b00 && w < 8) begin
        tick();
        w++;
      end
      chk("to_regrant", grant, 2'b01);
    end
    $display("timeout sequence: regrant=%b", grant);
`endif

    // Randomized run on both instances against the reference model.
    rst_n = 1'b0; rst2_n = 1'b0; req = 2'b00; req2 = 3'b000;
    tick();
    rst_n = 1'b1; rst2_n = 1'b1;
    m1 = mreset(2);
    m2 = mreset(3);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 2; b++) if ($urandom_range(3) == 0) req[b] = ~req[b];
      for (int b = 0; b < 3; b++) if ($urandom_range(3) == 0) req2[b] = ~req2[b];
      m1 = mstep(m1, {1'b0, req}, 2, 2, HOLD1);
      m2 = mstep(m2, req2, 3, 0, HOLD2);
      tick();
      eg = mgrant(m1);
      chk("rnd1_grant", grant, eg[1:0]);
      chk("rnd1_func", func_select, mfunc(m1, 6'b00_11_10));
      chk("rnd1_busy", busy, (m1.owner >= 0) || (m1.cool > 0));
      chk("rnd1_pre", preempted, m1.pre);
      chk("rnd2_grant", grant2, mgrant(m2));
      chk("rnd2_func", func2, mfunc(m2, 6'b01_11_10));
      chk("rnd2_busy", busy2, (m2.owner >= 0) || (m2.cool > 0));
      chk("rnd2_pre", pre2, m2.pre);
    end
    $display("random phase: 600 cycles on both instances");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
